uart_rx_deserializer: RTL and testbench
=======================================

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameters (name, default, meaning): CLKS_PER_BIT, 16, clk cycles per serial bit, even, >=4.
REQ-002 SHALL have parameter WORD_SIZE, 8, data bits per frame.
REQ-003 SHALL have parameter PARITY, 0, 0=none, 1=even, 2=odd.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port data_read, output, WORD_SIZE, last correctly received word.
REQ-008 SHALL have port rx_avbl_i, output, 1, one-cycle pulse: data_read holds a new word.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port parity_err, output, 1, one-cycle pulse: parity mismatch (PARITY!=0 only).
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer (reset value 1); rx_s below means the synchronized value.
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK; one bit counter; one cycle counter of width $clog2(CLKS_PER_BIT).
REQ-014 IDLE: the first edge with rx_s==0 is T0; SHALL then go to START with the cycle counter cleared.
REQ-015 SHALL sample rx_s at edges T0+H+k*CLKS_PER_BIT, where H=CLKS_PER_BIT/2 and k=0 is start, 1..WORD_SIZE is data, and the next k is parity (if enabled) then stop.
REQ-016 START: if the k=0 sample is 1 (glitch), SHALL return to IDLE with no output pulse; otherwise go to DATA.
REQ-017 DATA: SHALL shift bits in LSB first into an internal shift register; after WORD_SIZE samples, SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-018 PARITY: SHALL store the sampled bit; mismatch = XOR(data bits, parity bit) != 0 for even, == 0 for odd.
REQ-019 STOP, sample 1, no parity mismatch: SHALL load data_read from the shift register and assert rx_avbl_i for exactly one cycle (both visible after the stop-sample edge); then go to IDLE.
REQ-020 STOP, sample 1, parity mismatch: SHALL assert parity_err one cycle; data_read unchanged; no rx_avbl_i; go to IDLE.
REQ-021 STOP, sample 0: SHALL assert frame_err one cycle; data_read unchanged; no rx_avbl_i (parity_err also fires if mismatched); go to BREAK.
REQ-022 BREAK: SHALL stay until rx_s==1, then go to IDLE; a low line SHALL NOT produce repeated frames.
REQ-023 Leaving STOP at mid-stop-bit SHALL allow a back-to-back start bit (one stop bit, no idle gap) to be detected.
REQ-024 data_read SHALL change only in the cycle rx_avbl_i asserts; no two pulses SHALL overlap; at most one pulse per frame.
REQ-025 The counter SHALL wrap to 0 at CLKS_PER_BIT-1; no arithmetic SHALL overflow its declared width.

Reset
REQ-026 While rst==0 (asynchronously): state=IDLE; counters=0; shift register=0; data_read=0; rx_avbl_i, frame_err, parity_err, busy=0; synchronizer flops=1.
REQ-027 Reset mid-frame SHALL discard the partial word; after rst rises, the next complete frame SHALL be received correctly.
REQ-028 Reset deassertion SHALL NOT by itself produce a start detection, even if rx is low (BREAK-like wait until rx_s==1 first).

Verification
REQ-029 C=16, W=8, P=0, frame 0xA5 (start 0, 1,0,1,0,0,1,0,1, stop 1) -> data_read=0xA5, rx_avbl_i high exactly 1 cycle at T0+8+9*16, busy low afterwards.
REQ-030 rx low for 4 cycles then high -> START aborts at k=0 sample; no pulses; busy returns 0; data_read unchanged.
REQ-031 Frame 0x3C with stop bit 0, then rx held low 40 cycles, then high -> frame_err 1 cycle, no rx_avbl_i, data_read unchanged, state BREAK until rx high, then IDLE.
REQ-032 P=1, 0x07 sent with parity bit 0 (correct=1) -> parity_err 1 cycle, no rx_avbl_i; resend with parity 1 -> data_read=0x07, rx_avbl_i 1 cycle.
REQ-033 Back-to-back 0x00 then 0xFF (single stop bits, no gap) -> two rx_avbl_i pulses 160 cycles apart; data_read=0x00 then 0xFF.
REQ-034 rst low during bit 4 of 0x55, released, then 0x81 sent -> all outputs 0 during reset; single rx_avbl_i with data_read=0x81.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises rx, samples mid-bit, deserialises LSB-first words with optional parity.
// Latency: data_read/rx_avbl_i update on the edge that samples the stop bit (T0 + H + (WORD_SIZE+1[+1])*CLKS_PER_BIT).
// Backpressure: none; rx_avbl_i is a one-cycle strobe and data_read holds until the next good frame.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int WORD_SIZE    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [WORD_SIZE-1:0] data_read,
    output logic                 rx_avbl_i,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [1:0]           prime_q;
    logic                 armed;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [WORD_SIZE-1:0] shift_q;
    logic                 par_bit;
    logic                 par_calc;
    logic                 mismatch;
    logic                 tick;

    // Two-flop synchroniser; resets to idle-high so reset release looks like an idle line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    // START waits half a bit to reach mid-start; later states wait a full bit between samples
    assign tick = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);

    assign par_calc = (^shift_q) ^ par_bit;
    assign mismatch = (PARITY == 1) ? par_calc :
                      (PARITY == 2) ? ~par_calc : 1'b0;

    // Receive FSM with registered strobes. A start is only accepted once the line has been
    // seen high after reset (armed), so a line held low through reset is treated like a break.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            prime_q    <= 2'b00;
            armed      <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_bit    <= 1'b0;
            data_read  <= '0;
            rx_avbl_i  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_avbl_i  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            // prime_q[1] marks when rx_s reflects the real line rather than the reset value
            prime_q    <= {prime_q[0], 1'b1};
            if (prime_q[1] && rx_s) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (armed && !rx_s) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shift_q <= {rx_s, shift_q[WORD_SIZE-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (rx_s) begin
                            if (mismatch) begin
                                parity_err <= 1'b1;
                            end else begin
                                data_read <= shift_q;
                                rx_avbl_i <= 1'b1;
                            end
                            // leave at mid-stop so a back-to-back start edge is caught
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err  <= 1'b1;
                            parity_err <= mismatch;
                            state      <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frame table plus hand-written corner sequences.
// Latency: frames are driven at the negedge; the stop-sample strobe lands 155 edges after the start drive (no parity).
// Backpressure: not applicable; strobes are counted by a negedge monitor.
module tb_uart_rx_deserializer;

    logic       clk;
    logic       rst;
    logic       rx0;
    logic       rx1;
    logic [7:0] data_read0;
    logic [7:0] data_read1;
    logic       rx_avbl_i0, frame_err0, parity_err0, busy0;
    logic       rx_avbl_i1, frame_err1, parity_err1, busy1;

    int checks;
    int errors;
    int cyc;
    int t_drive;

    int avbl0, ferr0, perr0, avbl1, ferr1, perr1;
    int last_cyc0, prev_cyc0;
    logic [7:0] last_dat0, prev_dat0;

    uart_rx_deserializer #(.CLKS_PER_BIT(16), .WORD_SIZE(8), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_read(data_read0), .rx_avbl_i(rx_avbl_i0),
        .frame_err(frame_err0), .parity_err(parity_err0), .busy(busy0)
    );

    uart_rx_deserializer #(.CLKS_PER_BIT(16), .WORD_SIZE(8), .PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_read(data_read1), .rx_avbl_i(rx_avbl_i1),
        .frame_err(frame_err1), .parity_err(parity_err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count strobe-high cycles and remember when/what the last two words were
    always @(negedge clk) begin
        if (rx_avbl_i0) begin
            avbl0++;
            prev_cyc0 = last_cyc0;
            prev_dat0 = last_dat0;
            last_cyc0 = cyc;
            last_dat0 = data_read0;
        end
        if (frame_err0)  ferr0++;
        if (parity_err0) perr0++;
        if (rx_avbl_i1)  avbl1++;
        if (frame_err1)  ferr1++;
        if (parity_err1) perr1++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int which, input logic b);
        if (which == 0) rx0 = b;
        else            rx1 = b;
    endtask

    // Drives start, 8 data bits LSB first, optional parity, stop; leaves rx at the stop level
    task automatic send_frame(input int which, input logic [7:0] d, input bit with_par,
                              input logic par, input logic stop);
        t_drive = cyc;
        set_rx(which, 1'b0);
        hold(16);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            hold(16);
        end
        if (with_par) begin
            set_rx(which, par);
            hold(16);
        end
        set_rx(which, stop);
        hold(16);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_avbl;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int a0, f0, p0, a1, f1, p1;
        logic [7:0] dsave;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[6] = '{8'h80, 1'b1, 1, 0, 8'h80};

        checks = 0; errors = 0; cyc = 0;
        avbl0 = 0; ferr0 = 0; perr0 = 0; avbl1 = 0; ferr1 = 0; perr1 = 0;
        last_cyc0 = 0; prev_cyc0 = 0; last_dat0 = 0; prev_dat0 = 0;
        rst = 1'b0; rx0 = 1'b1; rx1 = 1'b1;

        // Reset state
        hold(4);
        check("rst_data0", data_read0, 0);
        check("rst_avbl0", rx_avbl_i0, 0);
        check("rst_ferr0", frame_err0, 0);
        check("rst_perr0", parity_err0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_data1", data_read1, 0);
        rst = 1'b1;
        hold(10);

        // Frame table
        for (int v = 0; v < 7; v++) begin
            a0 = avbl0; f0 = ferr0;
            send_frame(0, vecs[v].d, 1'b0, 1'b0, vecs[v].stop);
            rx0 = 1'b1;
            hold(20);
            check($sformatf("vec%0d_avbl", v), avbl0 - a0, vecs[v].exp_avbl);
            check($sformatf("vec%0d_ferr", v), ferr0 - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_data", v), data_read0, vecs[v].exp_data);
            check($sformatf("vec%0d_busy", v), busy0, 0);
            if (vecs[v].exp_avbl == 1)
                check($sformatf("vec%0d_latency", v), last_cyc0 - t_drive, 155);
        end

        // Glitch shorter than half a bit aborts in START
        a0 = avbl0; f0 = ferr0; dsave = data_read0;
        rx0 = 1'b0;
        hold(4);
        rx0 = 1'b1;
        hold(2);
        check("glitch_busy_high", busy0, 1);
        hold(30);
        check("glitch_busy_low", busy0, 0);
        check("glitch_pulses", (avbl0 - a0) + (ferr0 - f0), 0);
        check("glitch_data", data_read0, dsave);

        // Framing error followed by a long low line (break)
        a0 = avbl0; f0 = ferr0; dsave = data_read0;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        hold(40);
        check("brk_ferr", ferr0 - f0, 1);
        check("brk_avbl", avbl0 - a0, 0);
        check("brk_data", data_read0, dsave);
        check("brk_busy_held", busy0, 1);
        rx0 = 1'b1;
        hold(6);
        check("brk_busy_released", busy0, 0);
        hold(10);

        // Back-to-back frames with a single stop bit and no idle gap
        a0 = avbl0;
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        hold(20);
        check("b2b_count", avbl0 - a0, 2);
        check("b2b_spacing", last_cyc0 - prev_cyc0, 160);
        check("b2b_first", prev_dat0, 8'h00);
        check("b2b_second", last_dat0, 8'hFF);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        a1 = avbl1; p1 = perr1; f1 = ferr1;
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        rx1 = 1'b1;
        hold(20);
        check("par_bad_perr", perr1 - p1, 1);
        check("par_bad_avbl", avbl1 - a1, 0);
        check("par_bad_data", data_read1, 0);
        a1 = avbl1; p1 = perr1;
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        rx1 = 1'b1;
        hold(20);
        check("par_ok_perr", perr1 - p1, 0);
        check("par_ok_avbl", avbl1 - a1, 1);
        check("par_ok_data", data_read1, 8'h07);
        check("par_ferr", ferr1 - f1, 0);

        // Reset in the middle of 0x55 (during bit 4), released with the line low
        rx0 = 1'b0;
        hold(16);
        for (int i = 0; i < 4; i++) begin
            rx0 = (i % 2 == 0) ? 1'b1 : 1'b0;
            hold(16);
        end
        rx0 = 1'b1;
        hold(8);
        rst = 1'b0;
        rx0 = 1'b0;
        hold(3);
        check("mid_rst_data", data_read0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_strobes", rx_avbl_i0 + frame_err0 + parity_err0, 0);
        rst = 1'b1;
        a0 = avbl0; f0 = ferr0;
        hold(30);
        check("post_rst_low_busy", busy0, 0);
        check("post_rst_low_ferr", ferr0 - f0, 0);
        rx0 = 1'b1;
        hold(20);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        hold(20);
        check("post_rst_avbl", avbl0 - a0, 1);
        check("post_rst_data", data_read0, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
